// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register for inter-stage boundaries.
// Main entry drives the output. A skid entry absorbs one extra bundle, so
// in_ready depends only on registered state and rst. A flush drops every
// held entry and the input of that cycle. The saturating stall counter
// counts cycles in which a live output is blocked downstream.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 51,
  parameter logic [DATA_W-1:0] RST_VAL    = '0,
  parameter bit                CLEAR_DATA = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic [CNT_W-1:0]  stall_q,  stall_d;

  logic acc;
  logic drn;

  // The skid entry is the only reason to refuse input, so ready is registered.
  assign in_ready  = ~skid_v_q & ~rst;
  assign acc       = in_valid & in_ready & ~flush;
  assign drn       = main_v_q & out_ready;

  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign stall_cnt = stall_q;

  // Next-state for both entries and the stall counter; rst over flush over moves.
  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    stall_d  = stall_q;

    if (main_v_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_ONE;
    end

    if (rst) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      stall_d  = '0;
      if (CLEAR_DATA) begin
        main_d_d = RST_VAL;
        skid_d_d = RST_VAL;
      end
    end else if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (CLEAR_DATA) begin
        main_d_d = RST_VAL;
        skid_d_d = RST_VAL;
      end
    end else if (!main_v_q || drn) begin
      // Main frees up: refill from skid first to keep FIFO order.
      // in_ready is low whenever skid is full, so acc cannot coincide
      // with a skid-to-main advance.
      if (skid_v_q) begin
        main_v_d = 1'b1;
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
      end else if (acc) begin
        main_v_d = 1'b1;
        main_d_d = in_data;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d_d = in_data;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    main_v_q <= main_v_d;
    main_d_q <= main_d_d;
    skid_v_q <= skid_v_d;
    skid_d_q <= skid_d_d;
    stall_q  <= stall_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances share stimulus (default-like,
// 4-bit stall counter, data not cleared) against a FIFO scoreboard model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occupancy;
  logic [3:0]    s_stall_cnt;

  logic          n_in_ready, n_out_valid;
  logic [DW-1:0] n_out_data;
  logic [1:0]    n_occupancy;
  logic [15:0]   n_stall_cnt;

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_DATA(1'b1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

  pipe_stage_reg #(.DATA_W(DW), .CLEAR_DATA(1'b0), .CNT_W(16)) u_nc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_data(in_data), .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy), .stall_cnt(n_stall_cnt));

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [DW-1:0] sb[$];
  int unsigned   stall_m = 0;
  int unsigned   sat_m   = 0;

  typedef struct {
    logic          r, f, v, o;
    logic [DW-1:0] d;
    int unsigned   exp_occ;
    logic          exp_irdy;
    int unsigned   exp_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic v, input logic o,
                     input logic [DW-1:0] d, input int unsigned occ, input logic irdy,
                     input int unsigned st);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.o = o; t.d = d;
    t.exp_occ = occ; t.exp_irdy = irdy; t.exp_stall = st;
    vecs.push_back(t);
  endtask

  // One cycle: drive at negedge, score against the FIFO model, check after the edge.
  task automatic cyc(input logic r, input logic f, input logic v, input logic o,
                     input logic [DW-1:0] d);
    int unsigned   pre;
    logic [DW-1:0] exp_d;
    rst = r; flush = f; in_valid = v; out_ready = o; in_data = d;
    #1;
    pre = sb.size();
    chk("in_ready_pre", 32'(in_ready), 32'((pre < 2) && !r));
    if (!r && (pre > 0) && o) begin
      exp_d = sb.pop_front();
      chk("deliver", 32'(out_data), 32'(exp_d));
    end
    if (r) begin
      sb.delete();
      stall_m = 0;
      sat_m   = 0;
    end else begin
      if ((pre > 0) && !o) begin
        stall_m++;
        if (sat_m != 15) sat_m++;
      end
      if (f) sb.delete();
      else if (v && (pre < 2)) sb.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
    chk("occupancy", 32'(occupancy), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) chk("head_data", 32'(out_data), 32'(sb[0]));
    chk("stall_cnt", 32'(stall_cnt), stall_m);
    chk("stall_sat", 32'(s_stall_cnt), sat_m);
  endtask

  initial begin
    // rst flush vld rdy data            occ irdy stall
    add(1, 0, 0, 0, 16'h0000,           0,  0,   0);
    add(0, 0, 0, 1, 16'h0000,           0,  1,   0);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 1, 1, DW'(k),           1,  1,   0);
    add(0, 0, 0, 1, 16'h0000,           0,  1,   0);
    add(0, 0, 1, 0, 16'h000A,           1,  1,   0);
    add(0, 0, 1, 0, 16'h000B,           2,  0,   1);
    add(0, 0, 1, 0, 16'h000C,           2,  0,   2);
    add(0, 0, 1, 0, 16'h000C,           2,  0,   3);
    add(0, 0, 1, 1, 16'h000C,           1,  1,   3);
    add(0, 0, 1, 1, 16'h000C,           1,  1,   3);
    add(0, 0, 0, 1, 16'h0000,           0,  1,   3);
    add(0, 0, 1, 0, 16'h0011,           1,  1,   3);
    add(0, 0, 1, 0, 16'h0022,           2,  0,   4);
    add(0, 1, 1, 1, 16'h00DD,           0,  1,   4);
    add(0, 0, 0, 1, 16'h0000,           0,  1,   4);
    add(0, 0, 1, 0, 16'h0033,           1,  1,   4);
    add(0, 0, 1, 0, 16'h0044,           2,  0,   5);
    add(1, 0, 1, 0, 16'h0055,           0,  0,   0);
    add(0, 0, 0, 0, 16'h0000,           0,  1,   0);

    @(negedge clk);
    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].o, vecs[i].d);
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), vecs[i].exp_occ);
      chk($sformatf("vec%0d_irdy", i), 32'(in_ready), 32'(vecs[i].exp_irdy));
      chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), vecs[i].exp_stall);
    end

    // Flush without data clearing keeps the stale bundle visible but invalid.
    cyc(0, 0, 1, 0, 16'hABCD);
    chk("nc_loaded", 32'(n_out_data), 32'h0000ABCD);
    cyc(0, 1, 0, 0, 16'h0000);
    chk("nc_flush_valid", 32'(n_out_valid), 32'h0);
    chk("nc_flush_data", 32'(n_out_data), 32'h0000ABCD);
    chk("clr_flush_data", 32'(out_data), 32'h0);

    // Reset with two entries held clears data and counter.
    cyc(0, 0, 1, 0, 16'h0077);
    cyc(0, 0, 1, 0, 16'h0088);
    chk("full_occ", 32'(occupancy), 32'd2);
    cyc(1, 0, 0, 0, 16'h0000);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_irdy_high", 32'(in_ready), 32'h0);
    cyc(0, 0, 0, 0, 16'h0000);
    chk("rst_irdy_after", 32'(in_ready), 32'h1);

    // Hold one entry blocked for 20 cycles, then 3 more: 4-bit counter pins at 15.
    cyc(0, 0, 1, 0, 16'h0099);
    for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, 16'h0000);
    chk("sat_20", 32'(s_stall_cnt), 32'd15);
    chk("wide_20", 32'(stall_cnt), 32'd20);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 16'h0000);
    chk("sat_hold", 32'(s_stall_cnt), 32'd15);
    chk("stable_data", 32'(out_data), 32'h0099);
    cyc(0, 0, 0, 1, 16'h0000);
    chk("drained", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
